bin_to_bcd4: RTL

- Sequential double-dabble converter from an unsigned binary value to four BCD digits.
- Sits directly upstream of the 4-digit multiplexed seven-segment driver and feeds its num0..num3 inputs.
- Digit outputs change only when a conversion completes, so the display never shows partial results.
- Start/busy/done handshake lets a producer (counter, score, timer) request a new conversion.

---
 rtl/bin_to_bcd4.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/bin_to_bcd4.sv
// bin_to_bcd4: sequential double-dabble converter, unsigned binary -> four BCD digits.
//
// A conversion is requested with start_i while idle. The value on bin_i is captured,
// shifted through a 5-digit BCD scratch register over WIDTH cycles, and the low four
// digits are then published on num3_o..num0_o together with ovf_o (value > 9999).
// The digit outputs change only when a conversion completes, so a downstream display
// never sees partial results.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   start_i   conversion request, sampled only while idle
//   bin_i     unsigned input value, captured on the accepted start cycle
//   busy_o    high while a conversion is in progress (shift and done states)
//   done_o    one-cycle pulse; num*_o and ovf_o already hold the new result
//   ovf_o     last converted value exceeded 9999
//   num0_o    units digit        num1_o  tens digit
//   num2_o    hundreds digit     num3_o  thousands digit
//
// Build option: define BCD4_OVF_SATURATE_EN to force the digits to 9999 on overflow;
// without it the digits show the value modulo 10000.

module bin_to_bcd4 #(
    parameter int unsigned WIDTH = 14  // legal range 4..14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] bin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             ovf_o,
    output logic [3:0]       num0_o,
    output logic [3:0]       num1_o,
    output logic [3:0]       num2_o,
    output logic [3:0]       num3_o
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [19:0]      bcd_q, bcd_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [15:0]      digits_q, digits_d;
    logic             ovf_q, ovf_d;

    logic [19:0]      bcd_adj;
    logic [19:0]      bcd_shift;
    logic [WIDTH-1:0] sr_shift;
    logic             shift_ovf;
    logic [15:0]      shift_digits;

    // Add-3 correction on every digit that would reach 10 or more after doubling.
    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < 5; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end else begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4];
            end
        end
    end

    assign bcd_shift = {bcd_adj[18:0], sr_q[WIDTH-1]};
    assign sr_shift  = {sr_q[WIDTH-2:0], 1'b0};
    assign shift_ovf = (bcd_shift[19:16] != 4'd0);

`ifdef BCD4_OVF_SATURATE_EN
    assign shift_digits = shift_ovf ? 16'h9999 : bcd_shift[15:0];
`else
    assign shift_digits = bcd_shift[15:0];
`endif

    // Next-state logic. The published digits are loaded on the same edge that enters
    // the done state, so they are already valid while done_o is high.
    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        digits_d = digits_q;
        ovf_d    = ovf_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    sr_d    = bin_i;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                sr_d  = sr_shift;
                bcd_d = bcd_shift;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    digits_d = shift_digits;
                    ovf_d    = shift_ovf;
                    state_d  = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            sr_q     <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            digits_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            bcd_q    <= bcd_d;
            cnt_q    <= cnt_d;
            digits_q <= digits_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        busy_o = (state_q != StIdle);
        done_o = (state_q == StDone);
    end

    assign ovf_o  = ovf_q;
    assign num0_o = digits_q[3:0];
    assign num1_o = digits_q[7:4];
    assign num2_o = digits_q[11:8];
    assign num3_o = digits_q[15:12];

endmodule
